// File: rtl/charlie7x5_pkg.sv
// charlie7x5_pkg: shared scan FSM state, matrix geometry and LED-to-cathode helper
package charlie7x5_pkg;
  localparam int NUM_PHASES = 6;
  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;
  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;
  // LED n sits on anode n/6; its cathode skips over the anode pin itself
  function automatic int cathode_of(input int n);
    int j;
    j = n % 6;
    return j + ((j >= n / 6) ? 1 : 0);
  endfunction
endpackage

// File: rtl/charlie7x5_map.sv
// charlie7x5_map: turns the active anode phase and front buffer into pin values/enables
// Ports: drive_i (DRIVE state), cath_en_i (cathode gate), phase_i (anode 0..5),
//        lit_i (front buffer, bit c*7+r), o_o / oe_o (pin values / enables)
module charlie7x5_map
  import charlie7x5_pkg::*;
(
  input  logic                           drive_i,
  input  logic                           cath_en_i,
  input  logic [2:0]                     phase_i,
  input  logic [NUM_COLS*NUM_ROWS-1:0]   lit_i,
  output logic [6:0]                     o_o,
  output logic [6:0]                     oe_o
);
  always_comb begin
    o_o = '0;
    oe_o = '0;
    for (int n = 0; n < NUM_COLS * NUM_ROWS; n++)
      if (drive_i && cath_en_i && lit_i[n] && n / 6 == int'(phase_i)) oe_o[3'(cathode_of(n))] = 1'b1;
    if (drive_i) begin
      oe_o[phase_i] = 1'b1;
      o_o[phase_i] = 1'b1;
    end
  end
endmodule

// File: rtl/charlie7x5_scan.sv
// charlie7x5_scan: double-buffered 7x5 charlieplexed LED scanner with dead-time blanking
// Ports: clock, reset (sync, active-high); wr_stb/wr_addr/wr_data -> wr_ack (back-buffer column write);
//        swap_stb -> swap_ack (present back buffer at frame end); brightness (PWM build only);
//        charlie7x5_o / charlie7x5_oe (pin values / enables); frame_stb (end of frame).
// Build option: define CHARLIE7X5_PWM_EN to gate cathodes with a 4-bit brightness PWM.
module charlie7x5_scan
  import charlie7x5_pkg::*;
#(
  parameter int TICKS_PER_PHASE = 1024,
  parameter int DEAD_TICKS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_stb,
  input  logic [2:0] wr_addr,
  input  logic [6:0] wr_data,
  output logic       wr_ack,
  input  logic       swap_stb,
  output logic       swap_ack,
  input  logic [3:0] brightness,
  output logic [6:0] charlie7x5_o,
  output logic [6:0] charlie7x5_oe,
  output logic       frame_stb
);
  localparam int TW = $clog2((TICKS_PER_PHASE > DEAD_TICKS ? TICKS_PER_PHASE : DEAD_TICKS) + 1);
  state_e state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [NUM_COLS-1:0][NUM_ROWS-1:0] back_q, front_q;
  logic pending_q, wr_ack_q;
  logic blank_done, drive_done, frame_end, swap_now, cath_en;
  logic [6:0] map_o, map_oe;
  // a zero dead time still spends the single post-reset cycle in BLANK
  assign blank_done = (DEAD_TICKS <= 1) || tick_q == TW'(DEAD_TICKS - 1);
  assign drive_done = tick_q == TW'(TICKS_PER_PHASE - 1);
  assign frame_end = state_q == ST_DRIVE && drive_done && phase_q == 3'(NUM_PHASES - 1);
  assign swap_now = frame_end && pending_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_BLANK;
      phase_q <= '0;
      tick_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tick_q <= tick_d;
    end
  end
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tick_d = tick_q + 1'b1;
    if (state_q == ST_BLANK && blank_done) begin
      state_d = ST_DRIVE;
      tick_d = '0;
    end
    if (state_q == ST_DRIVE && drive_done) begin
      state_d = DEAD_TICKS == 0 ? ST_DRIVE : ST_BLANK;
      tick_d = '0;
      phase_d = phase_q == 3'(NUM_PHASES - 1) ? 3'd0 : phase_q + 1'b1;
    end
  end
  // the swap copies the pre-write back buffer; a coincident write lands in back only
  always_ff @(posedge clock) begin
    if (reset) begin
      back_q <= '0;
      front_q <= '0;
      pending_q <= 1'b0;
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= wr_stb;
      if (wr_stb && wr_addr < 3'(NUM_COLS)) back_q[wr_addr] <= wr_data;
      if (swap_now) front_q <= back_q;
      pending_q <= swap_now ? 1'b0 : pending_q | swap_stb;
    end
  end
`ifdef CHARLIE7X5_PWM_EN
  logic [3:0] pwm_q;
  always_ff @(posedge clock) begin
    if (reset) pwm_q <= '0;
    else if (state_q == ST_DRIVE) pwm_q <= pwm_q + 1'b1;
  end
  assign cath_en = pwm_q < brightness;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign cath_en = 1'b1;
`endif
  charlie7x5_map u_map (
    .drive_i  (state_q == ST_DRIVE),
    .cath_en_i(cath_en),
    .phase_i  (phase_q),
    .lit_i    (front_q),
    .o_o      (map_o),
    .oe_o     (map_oe)
  );
  // outputs are forced quiet while reset is held
  always_comb begin
    charlie7x5_o = reset ? 7'd0 : map_o;
    charlie7x5_oe = reset ? 7'd0 : map_oe;
    frame_stb = ~reset & frame_end;
    swap_ack = ~reset & swap_now;
    wr_ack = ~reset & wr_ack_q;
  end
endmodule

// File: tb/tb_charlie7x5_scan.sv
// tb_charlie7x5_scan: randomized and directed checks against a frame-position reference model
module tb_charlie7x5_scan;
  localparam int TPP = 4;
  localparam int DEAD = 1;
  localparam int PL = TPP + DEAD;
  localparam int FL = 6 * PL;
  logic clock = 1'b0;
  logic reset, wr_stb, swap_stb;
  logic [2:0] wr_addr;
  logic [6:0] wr_data;
  logic [3:0] brightness;
  logic wr_ack, swap_ack, frame_stb;
  logic [6:0] charlie7x5_o, charlie7x5_oe;
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int dcnt = 0;
  bit m_pend = 0;
  bit m_prev_wr = 0;
  logic [6:0] m_back[5];
  logic [6:0] m_front[5];
  always #5 clock = ~clock;
  charlie7x5_scan #(.TICKS_PER_PHASE(TPP), .DEAD_TICKS(DEAD)) dut (
    .clock(clock), .reset(reset), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .swap_stb(swap_stb), .swap_ack(swap_ack), .brightness(brightness),
    .charlie7x5_o(charlie7x5_o), .charlie7x5_oe(charlie7x5_oe), .frame_stb(frame_stb)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  // expected pins: walk every pin of the active anode back to the LED it would light
  task automatic check_cycle();
    int p, a, j, n;
    bit drv, fe, cath;
    logic [6:0] eo, eoe;
    p = cyc % FL;
    a = p / PL;
    drv = (p % PL) >= DEAD;
    fe = p == FL - 1;
`ifdef CHARLIE7X5_PWM_EN
    cath = (dcnt % 16) < int'(brightness);
`else
    cath = 1'b1;
`endif
    eo = '0;
    eoe = '0;
    if (drv) begin
      eo[a] = 1'b1;
      eoe[a] = 1'b1;
      for (int k = 0; k < 7; k++) begin
        if (k == a) continue;
        j = k > a ? k - 1 : k;
        n = a * 6 + j;
        if (n < 35 && cath && m_front[n / 7][n % 7]) eoe[k] = 1'b1;
      end
    end
    if (reset) begin
      eo = '0;
      eoe = '0;
      fe = 1'b0;
    end
    chk("pin_o", charlie7x5_o, eo);
    chk("pin_oe", charlie7x5_oe, eoe);
    chk("frame_stb", frame_stb, fe);
    chk("swap_ack", swap_ack, fe && m_pend);
    chk("wr_ack", wr_ack, !reset && m_prev_wr);
  endtask
  task automatic model_update(input bit ws, input logic [2:0] wa, input logic [6:0] wd, input bit ss, input bit rs);
    if (rs) begin
      cyc = 0;
      dcnt = 0;
      m_pend = 0;
      m_prev_wr = 0;
      for (int c = 0; c < 5; c++) begin
        m_back[c] = '0;
        m_front[c] = '0;
      end
    end else begin
      if ((cyc % PL) >= DEAD) dcnt++;
      if (cyc % FL == FL - 1 && m_pend) begin
        m_front = m_back;
        m_pend = 0;
      end else if (ss) m_pend = 1;
      if (ws && wa < 5) m_back[wa] = wd;
      m_prev_wr = ws;
      cyc++;
    end
  endtask
  task automatic step(input bit ws, input logic [2:0] wa, input logic [6:0] wd, input bit ss, input bit rs);
    wr_stb = ws;
    wr_addr = wa;
    wr_data = wd;
    swap_stb = ss;
    reset = rs;
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    model_update(ws, wa, wd, ss, rs);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, 7'd0, 0, 0);
  endtask
  initial begin
    brightness = 4'd15;
    for (int i = 0; i < 3; i++) step(0, 3'd0, 7'd0, 0, 1);
    idle(2 * FL + 5);
    step(1, 3'd0, 7'h01, 0, 0);
    step(0, 3'd0, 7'd0, 1, 0);
    idle(2 * FL + 5);
    step(1, 3'd4, 7'h40, 1, 0);
    idle(2 * FL + 5);
    step(1, 3'd2, 7'h7f, 0, 0);
    idle(FL + 5);
    for (int i = 0; i < FL && cyc % FL != FL - 1; i++) idle(1);
    step(0, 3'd0, 7'd0, 1, 0);
    idle(2 * FL + 5);
    step(1, 3'd6, 7'h7f, 0, 0);
    step(1, 3'd7, 7'h55, 1, 0);
    idle(2 * FL + 5);
    for (int i = 0; i < PL && (cyc % PL) < DEAD; i++) idle(1);
    step(1, 3'd1, 7'h2a, 0, 0);
    step(0, 3'd0, 7'd0, 0, 1);
    idle(FL);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) brightness = 4'($urandom);
      step($urandom_range(0, 1) == 1, 3'($urandom), 7'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 199) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
